// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//
// Buffers results from the combinational ALU in a small circular FIFO with a
// valid/ready handshake on each side. Writeback or trace logic drains it at
// its own pace. Alongside the FIFO, a set of sticky status flags accumulates
// the flags of every accepted result until software clears them.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset; empties the FIFO at once
//   in_valid     - producer presents an ALU result
//   in_ready     - FIFO can accept an entry (not full)
//   in_opcode    - ALU opcode that produced the result
//   in_out       - ALU result
//   in_zero/in_carry/in_overflow/in_sign - ALU flags
//   out_valid    - head entry is valid (not empty)
//   out_ready    - consumer accepts the head entry
//   out_data     - head result (0 when empty)
//   out_opcode   - head opcode (0 when empty)
//   out_flags    - head flags {sign, overflow, carry, zero} (0 when empty)
//   count        - occupancy, 0..DEPTH
//   sticky_flags - accumulated flags {sign, overflow, carry, zero}
//   sticky_clr   - synchronous clear of sticky_flags
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_opcode,
    input  logic [WIDTH-1:0]         in_out,
    input  logic                     in_zero,
    input  logic                     in_carry,
    input  logic                     in_overflow,
    input  logic                     in_sign,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_opcode,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               sticky_flags,
    input  logic                     sticky_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0]    OpAdd  = 4'b0000;
    localparam logic [3:0]    OpSub  = 4'b0001;
    localparam logic [AW-1:0] PtrOne = AW'(1);
    localparam logic [CW-1:0] CntOne = CW'(1);
    localparam logic [CW-1:0] CntMax = CW'(DEPTH);

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       sticky_q, sticky_d;

    logic [WIDTH-1:0] dataMem_q [DEPTH];
    logic [3:0]       opMem_q   [DEPTH];
    logic [3:0]       flagMem_q [DEPTH];

    logic             full;
    logic             empty;
    logic             pushEn;
    logic             popEn;
    logic             isAddSub;
    logic [3:0]       inFlags;
    logic [3:0]       maskedFlags;

    // Pointers wrap naturally; only the count tells full from empty.
    assign full   = (count_q == CntMax);
    assign empty  = (count_q == '0);
    assign pushEn = in_valid && !full;
    assign popEn  = out_ready && !empty;

    // Carry and overflow are only meaningful for arithmetic opcodes.
    assign isAddSub    = (in_opcode == OpAdd) || (in_opcode == OpSub);
    assign inFlags     = {in_sign, in_overflow, in_carry, in_zero};
    assign maskedFlags = {in_sign, in_overflow & isAddSub, in_carry & isAddSub, in_zero};

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        sticky_d = sticky_q;

        if (pushEn) begin
            wrPtr_d = wrPtr_q + PtrOne;
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PtrOne;
        end

        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // Clear first, then the accepted push sets its masked flags.
        if (sticky_clr) begin
            sticky_d = '0;
        end
        if (pushEn) begin
            sticky_d = sticky_d | maskedFlags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage needs no reset: reads are gated by out_valid.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            dataMem_q[wrPtr_q] <= in_out;
            opMem_q[wrPtr_q]   <= in_opcode;
            flagMem_q[wrPtr_q] <= inFlags;
        end
    end

    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign out_data     = empty ? '0 : dataMem_q[rdPtr_q];
    assign out_opcode   = empty ? '0 : opMem_q[rdPtr_q];
    assign out_flags    = empty ? '0 : flagMem_q[rdPtr_q];
    assign count        = count_q;
    assign sticky_flags = sticky_q;

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the combinational `alu`. Captures each ALU result (`out`, `opcode`, Z/C/O/S flags) into a small FIFO with a valid/ready handshake.
- The writeback or trace logic drains the FIFO at its own pace.
- Also keeps sticky status flags that accumulate across all accepted results until software clears them.

Parameters:
- WIDTH, 32, datapath width. Must match the ALU's WIDTH.
- DEPTH, 4, number of FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer presents an ALU result this cycle
- in_ready  output  1  FIFO can accept an entry; equals !full
- in_opcode  input  4  ALU opcode that produced the result
- in_out  input  WIDTH  ALU result
- in_zero  input  1  ALU zero flag
- in_carry  input  1  ALU carry flag
- in_overflow  input  1  ALU overflow flag
- in_sign  input  1  ALU sign flag
- out_valid  output  1  head entry is valid; equals !empty
- out_ready  input  1  consumer accepts the head entry
- out_data  output  WIDTH  head result
- out_opcode  output  4  head opcode
- out_flags  output  4  head flags, ordered {sign, overflow, carry, zero}
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- sticky_flags  output  4  accumulated flags, ordered {sign, overflow, carry, zero}
- sticky_clr  input  1  synchronous clear of sticky_flags

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read/write pointers and count go to 0; sticky_flags go to 0.
  - out_valid=0, in_ready=1.
  - out_data, out_opcode and out_flags read 0.
  - A reset asserted mid-stream discards every stored entry immediately, with no clock edge needed.
- Push: occurs when in_valid && in_ready at a rising edge. Writes {in_opcode, in_out, flags} at wptr; wptr advances modulo DEPTH.
- Pop: occurs when out_valid && out_ready at a rising edge. rptr advances modulo DEPTH.
- Output path:
  - out_data, out_opcode and out_flags come from storage at rptr through a combinational read.
  - All three read 0 whenever out_valid=0.
- Latency: an entry pushed at edge N shows out_valid=1 and its data during the cycle after edge N. There is no combinational in-to-out path.
- Full and empty:
  - Full means count==DEPTH. in_ready=0, and in_valid is ignored with no overwrite and no drop counting.
  - Empty means count==0. out_valid=0, and out_ready is ignored.
- Simultaneous push and pop:
  - When 0<count<DEPTH, both occur and count is unchanged.
  - When empty, only the push occurs.
  - When full, only the pop occurs; in_ready is low that cycle because it is derived from registered state.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.
- Sticky flags, on each accepted push:
  - sticky_flags[0] (zero) |= in_zero.
  - sticky_flags[3] (sign) |= in_sign.
  - sticky_flags[1] (carry) and sticky_flags[2] (overflow) |= their inputs only when in_opcode is 4'b0000 (ADD) or 4'b0001 (SUB). For all other opcodes these inputs are ignored.
- Sticky clear:
  - sticky_clr=1 at an edge with no push sets sticky_flags to 0.
  - sticky_clr=1 together with a push gives sticky_flags = that push's masked flags. Clear is applied first, then set.
- Opcode values outside the ALU's defined set are stored and forwarded unchanged.
- Inputs are not checked for X: the producer is responsible for holding in_* stable while in_valid=1 && in_ready=0.

Test Plan:
- Reset then single push:
  - After reset: count=0, in_ready=1, out_valid=0, out_data=0.
  - Push ADD, in_out=32'h00000008, flags all 0.
  - Next cycle: out_valid=1, out_data=32'h00000008, out_opcode=4'b0000, count=1.
  - Pop: count=0.
- Fill and back-pressure (DEPTH=4):
  - With out_ready=0, push results 1,2,3,4: count=4, in_ready=0.
  - A 5th in_valid with value 5 is not accepted.
  - Drain with out_ready=1: order is 1,2,3,4, then out_valid=0.
- Simultaneous push and pop with wrap:
  - Hold count=2 while streaming push+pop every cycle for 10 cycles, values 10..19.
  - count stays 2 throughout; outputs appear in order with no loss across pointer wrap.
- Sticky masking:
  - Push AND (4'b0010) with carry=1, overflow=1: sticky_flags=4'b0000.
  - Push SUB (4'b0001) with overflow=1, sign=1: sticky_flags=4'b1100.
  - Push XOR with zero=1: sticky_flags=4'b1101.
- Clear priority:
  - sticky_flags=4'b1101, then sticky_clr=1 together with a push of ADD with carry=1: sticky_flags=4'b0010.
  - sticky_clr=1 alone: sticky_flags=4'b0000.
- Asynchronous reset mid-stream:
  - With count=3, pull rst_n low between edges.
  - Immediately: out_valid=0, count=0, sticky_flags=0, in_ready=1.
  - After release, the first push is read back correctly.
